// File: rtl/axi_master_addr_issue_if.sv
// AXI4 read/write address channel (AR or AW) between the command issuer and the interconnect.
interface axi_master_addr_issue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]   m_ax_id;
  logic [ADDR_WIDTH-1:0] m_ax_addr;
  logic [7:0]            m_ax_len;
  logic [2:0]            m_ax_size;
  logic [1:0]            m_ax_burst;
  logic                  m_ax_valid;
  logic                  m_ax_ready;

  modport master (
    output m_ax_id, m_ax_addr, m_ax_len, m_ax_size, m_ax_burst, m_ax_valid,
    input  m_ax_ready
  );

  modport slave (
    input  m_ax_id, m_ax_addr, m_ax_len, m_ax_size, m_ax_burst, m_ax_valid,
    output m_ax_ready
  );
endinterface

// File: rtl/axi_master_addr_issue.sv
// Pops packed {len, addr, id} commands from the address FIFO and issues them on an AXI4
// address channel, splitting INCR bursts at 4 KB boundaries. One cmd_done per FIFO entry.
module axi_master_addr_issue #(
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int SIZE           = 3,
  parameter int BOUNDARY_SPLIT = 1,
  localparam int CMD_WIDTH     = 8 + ADDR_WIDTH + ID_WIDTH
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  output logic                   fifo_rd_en,
  input  logic [CMD_WIDTH-1:0]   fifo_rd_data,
  input  logic                   fifo_rd_empty,
  axi_master_addr_issue_if.master ax,
  output logic                   cmd_done,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, ISSUE} state_t;

  state_t                state;
  logic                  rd_en_q;
  logic                  valid_q;
  logic                  done_q;
  logic                  busy_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [8:0]            rem_q;
  logic [8:0]            sub_q;

  logic [ID_WIDTH-1:0]   load_id;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [8:0]            load_rem;
  logic [8:0]            load_sub;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [8:0]            next_rem;
  logic [8:0]            next_sub;

  // Beats of the sub-burst starting at an address with the given low 12 bits:
  // limited by what is left of the command and by the distance to the next 4 KB page.
  function automatic logic [8:0] sub_beats(input logic [11:0] low, input logic [8:0] rem);
    logic [12:0] off;
    logic [12:0] beats_to_bnd;
    off          = ({1'b0, low} >> SIZE) << SIZE;
    beats_to_bnd = (13'd4096 - off) >> SIZE;
    if (BOUNDARY_SPLIT == 0 || {4'b0, rem} <= beats_to_bnd) return rem;
    return beats_to_bnd[8:0];
  endfunction

  // Decode the FIFO entry and precompute the sub-burst following the current one.
  always_comb begin
    load_id   = fifo_rd_data[ID_WIDTH-1:0];
    load_addr = fifo_rd_data[ID_WIDTH +: ADDR_WIDTH];
    load_rem  = {1'b0, fifo_rd_data[CMD_WIDTH-1 -: 8]} + 9'd1;
    load_sub  = sub_beats(load_addr[11:0], load_rem);
    next_addr = {addr_q[ADDR_WIDTH-1:12] + (ADDR_WIDTH-12)'(1), 12'h000};
    next_rem  = rem_q - sub_q;
    next_sub  = sub_beats(next_addr[11:0], next_rem);
  end

  // Command sequencer: pop, wait for RAM latency, load, then issue sub-bursts until exhausted.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state   <= IDLE;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      sub_q   <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_rd_empty) begin
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          id_q    <= load_id;
          addr_q  <= load_addr;
          rem_q   <= load_rem;
          sub_q   <= load_sub;
          len_q   <= 8'(load_sub - 9'd1);
          valid_q <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (ax.m_ax_ready) begin
            valid_q <= 1'b0;
            if (rem_q == sub_q) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              // Next sub-burst is loaded now and presented after one idle cycle.
              rem_q  <= next_rem;
              sub_q  <= next_sub;
              addr_q <= next_addr;
              len_q  <= 8'(next_sub - 9'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en    = rd_en_q;
  assign cmd_done      = done_q;
  assign busy          = busy_q;
  assign ax.m_ax_id    = id_q;
  assign ax.m_ax_addr  = addr_q;
  assign ax.m_ax_len   = len_q;
  assign ax.m_ax_size  = 3'(SIZE);
  assign ax.m_ax_burst = 2'b01;
  assign ax.m_ax_valid = valid_q;

endmodule

// File: tb/tb_axi_master_addr_issue.sv
// Bench for axi_master_addr_issue: two instances (SIZE=3 and SIZE=0), each fed from a FIFO
// model; issued bursts are compared with a page-splitting reference model.
module tb_axi_master_addr_issue;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ready = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        rd_en_a, empty_a, done_a, busy_a;
  logic        rd_en_b, empty_b, done_b, busy_b;
  logic [43:0] rd_data_a, rd_data_b;
  logic [43:0] mem_a [64];
  logic [43:0] mem_b [64];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;

  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);

  axi_master_addr_issue_if #(.ADDR_WIDTH(32), .ID_WIDTH(4)) if_a ();
  axi_master_addr_issue_if #(.ADDR_WIDTH(32), .ID_WIDTH(4)) if_b ();
  assign if_a.m_ax_ready = ready;
  assign if_b.m_ax_ready = ready;

  axi_master_addr_issue #(.ADDR_WIDTH(32), .ID_WIDTH(4), .SIZE(3), .BOUNDARY_SPLIT(1)) dut_a (
    .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data_a),
    .fifo_rd_empty(empty_a), .ax(if_a), .cmd_done(done_a), .busy(busy_a));

  axi_master_addr_issue #(.ADDR_WIDTH(32), .ID_WIDTH(4), .SIZE(0), .BOUNDARY_SPLIT(1)) dut_b (
    .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data_b),
    .fifo_rd_empty(empty_b), .ax(if_b), .cmd_done(done_b), .busy(busy_b));

  // FIFO read side: unregistered RAM, data one cycle after the pop.
  always @(posedge clk) begin
    if (rd_en_a && wp_a != rp_a) begin
      rd_data_a <= mem_a[rp_a % 64];
      rp_a      <= rp_a + 1;
    end
    if (rd_en_b && wp_b != rp_b) begin
      rd_data_b <= mem_b[rp_b % 64];
      rp_b      <= rp_b + 1;
    end
  end

  // Monitor: record handshakes, done pulses and pops, sampled mid-cycle.
  burst_t hs_a [512];
  burst_t hs_b [512];
  int hs_cyc_a [512];
  int hs_na = 0, hs_nb = 0, done_na = 0, done_nb = 0, en_na = 0, en_nb = 0;
  int done_cyc_a = 0, cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst && if_a.m_ax_valid && ready) begin
      hs_a[hs_na % 512]     <= {if_a.m_ax_id, if_a.m_ax_addr, if_a.m_ax_len};
      hs_cyc_a[hs_na % 512] <= cyc;
      hs_na                 <= hs_na + 1;
    end
    if (!rst && if_b.m_ax_valid && ready) begin
      hs_b[hs_nb % 512] <= {if_b.m_ax_id, if_b.m_ax_addr, if_b.m_ax_len};
      hs_nb             <= hs_nb + 1;
    end
    if (done_a) begin
      done_na    <= done_na + 1;
      done_cyc_a <= cyc;
    end
    if (done_b) done_nb <= done_nb + 1;
    if (rd_en_a) en_na <= en_na + 1;
    if (rd_en_b) en_nb <= en_nb + 1;
  end

  burst_t exp_q[$];
  burst_t exp_qb[$];

  // Reference: walk the command page by page; each piece runs to the end of its 4 KB page.
  function automatic void model(input logic [31:0] addr, input int len, input logic [3:0] id,
                                input int s, input bit to_b);
    longint a, off, rem, room, n, bpb;
    burst_t b;
    a   = longint'(addr);
    rem = longint'(len) + 1;
    bpb = longint'(1) << s;
    while (rem > 0) begin
      off  = ((a % 4096) / bpb) * bpb;
      room = (4096 - off) / bpb;
      n    = (rem < room) ? rem : room;
      b    = {id, a[31:0], 8'(n - 1)};
      if (to_b) exp_qb.push_back(b);
      else exp_q.push_back(b);
      rem = rem - n;
      a   = (((a / 4096) + 1) * 4096) % 64'h1_0000_0000;
    end
  endfunction

  task automatic push_a(input logic [7:0] len, input logic [31:0] addr, input logic [3:0] id);
    mem_a[wp_a % 64] = {len, addr, id};
    wp_a = wp_a + 1;
  endtask

  task automatic push_b(input logic [7:0] len, input logic [31:0] addr, input logic [3:0] id);
    mem_b[wp_b % 64] = {len, addr, id};
    wp_b = wp_b + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_until(input int tgt_a, input int tgt_b, input int budget, input bit rnd,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
      if (done_na >= tgt_a && done_nb >= tgt_b) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    push_a(8'd15, 32'h0000_1000, 4'd3);
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (rd_en_a !== 1'b0) begin n_fail++; $display("FAIL reset rd_en: got %b want 0", rd_en_a); end
      n_cmp++; if (if_a.m_ax_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", if_a.m_ax_valid); end
      n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset cmd_done: got %b want 0", done_a); end
      n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy_a); end
      n_cmp++; if ({if_a.m_ax_id, if_a.m_ax_addr, if_a.m_ax_len} !== 44'h0) begin n_fail++; $display("FAIL reset fields: got %h want 0", {if_a.m_ax_id, if_a.m_ax_addr, if_a.m_ax_len}); end
    end
    n_cmp++; if (if_a.m_ax_size !== 3'd3) begin n_fail++; $display("FAIL size: got %0d want 3", if_a.m_ax_size); end
    n_cmp++; if (if_b.m_ax_size !== 3'd0) begin n_fail++; $display("FAIL size_b: got %0d want 0", if_b.m_ax_size); end
    n_cmp++; if (if_a.m_ax_burst !== 2'b01) begin n_fail++; $display("FAIL burst: got %b want 01", if_a.m_ax_burst); end
  endtask

  task automatic test_single;
    bit ok;
    int hs0 = hs_na, d0 = done_na, e0 = en_na;
    exp_q.delete();
    model(32'h0000_1000, 15, 4'd3, 3, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; ready = 1'b1;
    run_until(d0 + 1, done_nb, 40, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single timeout: done %0d want %0d", done_na - d0, 1); end
    idle(4);
    n_cmp++; if (done_na - d0 != 1) begin n_fail++; $display("FAIL single done count: got %0d want 1", done_na - d0); end
    n_cmp++; if (en_na - e0 != 1) begin n_fail++; $display("FAIL single pops: got %0d want 1", en_na - e0); end
    n_cmp++; if (hs_na - hs0 != exp_q.size()) begin n_fail++; $display("FAIL single issues: got %0d want %0d", hs_na - hs0, exp_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++; if (hs_a[(hs0 + i) % 512] !== exp_q[i]) begin n_fail++; $display("FAIL single burst %0d: got %h want %h", i, hs_a[(hs0 + i) % 512], exp_q[i]); end
    end
  endtask

  task automatic test_split;
    bit ok;
    int hs0 = hs_na, d0 = done_na;
    exp_q.delete();
    model(32'h0000_0FF0, 7, 4'd9, 3, 1'b0);
    push_a(8'd7, 32'h0000_0FF0, 4'd9);
    run_until(d0 + 1, done_nb, 40, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL split timeout: done %0d want 1", done_na - d0); end
    idle(4);
    n_cmp++; if (done_na - d0 != 1) begin n_fail++; $display("FAIL split done count: got %0d want 1", done_na - d0); end
    n_cmp++; if (hs_na - hs0 != 2) begin n_fail++; $display("FAIL split issues: got %0d want 2", hs_na - hs0); end
    foreach (exp_q[i]) begin
      n_cmp++; if (hs_a[(hs0 + i) % 512] !== exp_q[i]) begin n_fail++; $display("FAIL split burst %0d: got %h want %h", i, hs_a[(hs0 + i) % 512], exp_q[i]); end
    end
    n_cmp++; if (hs_cyc_a[(hs0 + 1) % 512] - hs_cyc_a[hs0 % 512] != 2) begin n_fail++; $display("FAIL split gap: got %0d want 2", hs_cyc_a[(hs0 + 1) % 512] - hs_cyc_a[hs0 % 512]); end
    n_cmp++; if (done_cyc_a != hs_cyc_a[(hs0 + 1) % 512] + 1) begin n_fail++; $display("FAIL split done timing: got %0d want %0d", done_cyc_a, hs_cyc_a[(hs0 + 1) % 512] + 1); end
  endtask

  task automatic test_backpressure;
    bit ok, seen;
    int hs0 = hs_na, d0 = done_na;
    exp_q.delete();
    model(32'h2000_0100, 9, 4'd5, 3, 1'b0);
    ready = 1'b0;
    push_a(8'd9, 32'h2000_0100, 4'd5);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = if_a.m_ax_valid;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL bp valid timeout: got 0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (if_a.m_ax_valid !== 1'b1) begin n_fail++; $display("FAIL bp valid hold %0d: got %b want 1", i, if_a.m_ax_valid); end
      n_cmp++; if ({if_a.m_ax_id, if_a.m_ax_addr, if_a.m_ax_len} !== exp_q[0]) begin n_fail++; $display("FAIL bp fields %0d: got %h want %h", i, {if_a.m_ax_id, if_a.m_ax_addr, if_a.m_ax_len}, exp_q[0]); end
    end
    @(posedge clk); #1;
    ready = 1'b1;
    run_until(d0 + 1, done_nb, 20, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp done timeout: got %0d want 1", done_na - d0); end
    idle(3);
    n_cmp++; if (hs_na - hs0 != 1 || hs_a[hs0 % 512] !== exp_q[0]) begin n_fail++; $display("FAIL bp issue: got %0d x %h want 1 x %h", hs_na - hs0, hs_a[hs0 % 512], exp_q[0]); end
  endtask

  task automatic test_max_burst;
    bit ok;
    int hsb0 = hs_nb, db0 = done_nb, hs0 = hs_na, d0 = done_na;
    exp_qb.delete();
    exp_q.delete();
    model(32'h0000_0F80, 255, 4'd1, 0, 1'b1);
    model(32'hFFFF_FFF8, 3, 4'd2, 3, 1'b0);
    push_b(8'd255, 32'h0000_0F80, 4'd1);
    push_a(8'd3, 32'hFFFF_FFF8, 4'd2);
    run_until(d0 + 1, db0 + 1, 60, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL max timeout: got %0d/%0d want 1/1", done_na - d0, done_nb - db0); end
    idle(4);
    n_cmp++; if (hs_nb - hsb0 != 2) begin n_fail++; $display("FAIL max issues: got %0d want 2", hs_nb - hsb0); end
    foreach (exp_qb[i]) begin
      n_cmp++; if (hs_b[(hsb0 + i) % 512] !== exp_qb[i]) begin n_fail++; $display("FAIL max burst %0d: got %h want %h", i, hs_b[(hsb0 + i) % 512], exp_qb[i]); end
    end
    n_cmp++; if (hs_na - hs0 != 2) begin n_fail++; $display("FAIL wrap issues: got %0d want 2", hs_na - hs0); end
    foreach (exp_q[i]) begin
      n_cmp++; if (hs_a[(hs0 + i) % 512] !== exp_q[i]) begin n_fail++; $display("FAIL wrap burst %0d: got %h want %h", i, hs_a[(hs0 + i) % 512], exp_q[i]); end
    end
    n_cmp++; if (done_nb - db0 != 1 || done_na - d0 != 1) begin n_fail++; $display("FAIL max done: got %0d/%0d want 1/1", done_nb - db0, done_na - d0); end
  endtask

  task automatic test_back_to_back;
    bit ok, seen;
    int hs0 = hs_na, d0 = done_na, e0 = en_na;
    exp_q.delete();
    model(32'h0000_0008, 0, 4'd6, 3, 1'b0);
    model(32'h0000_7800, 255, 4'd7, 3, 1'b0);
    model(32'h1234_5FF8, 1, 4'd8, 3, 1'b0);
    push_a(8'd0, 32'h0000_0008, 4'd6);
    push_a(8'd255, 32'h0000_7800, 4'd7);
    push_a(8'd1, 32'h1234_5FF8, 4'd8);
    ready = 1'b1;
    run_until(d0 + 3, done_nb, 80, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b timeout: got %0d want 3", done_na - d0); end
    idle(4);
    n_cmp++; if (done_na - d0 != 3) begin n_fail++; $display("FAIL b2b done: got %0d want 3", done_na - d0); end
    n_cmp++; if (en_na - e0 != 3) begin n_fail++; $display("FAIL b2b pops: got %0d want 3", en_na - e0); end
    n_cmp++; if (hs_na - hs0 != exp_q.size()) begin n_fail++; $display("FAIL b2b issues: got %0d want %0d", hs_na - hs0, exp_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++; if (hs_a[(hs0 + i) % 512] !== exp_q[i]) begin n_fail++; $display("FAIL b2b burst %0d: got %h want %h", i, hs_a[(hs0 + i) % 512], exp_q[i]); end
    end

    // Reset while the second of three commands waits in ISSUE.
    hs0 = hs_na; d0 = done_na; e0 = en_na;
    exp_q.delete();
    model(32'h0000_4000, 3, 4'd1, 3, 1'b0);
    model(32'h0000_6FC0, 7, 4'd4, 3, 1'b0);
    push_a(8'd3, 32'h0000_4000, 4'd1);
    push_a(8'd31, 32'h0000_5FF8, 4'd2);
    push_a(8'd7, 32'h0000_6FC0, 4'd4);
    run_until(d0 + 1, done_nb, 40, 1'b0, ok);
    ready = 1'b0;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst cmd1 timeout: got %0d want 1", done_na - d0); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = if_a.m_ax_valid;
    end
    n_cmp++; if (!seen || if_a.m_ax_addr !== 32'h0000_5FF8) begin n_fail++; $display("FAIL rst cmd2 issue: got %b %h want 1 00005ff8", seen, if_a.m_ax_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (if_a.m_ax_valid !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rst valid/busy: got %b/%b want 0/0", if_a.m_ax_valid, busy_a); end
    rst = 1'b0;
    ready = 1'b1;
    run_until(d0 + 2, done_nb, 40, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst cmd3 timeout: got %0d want 2", done_na - d0); end
    idle(4);
    n_cmp++; if (done_na - d0 != 2) begin n_fail++; $display("FAIL rst done count: got %0d want 2", done_na - d0); end
    n_cmp++; if (en_na - e0 != 3) begin n_fail++; $display("FAIL rst pops: got %0d want 3", en_na - e0); end
    n_cmp++; if (hs_na - hs0 != exp_q.size()) begin n_fail++; $display("FAIL rst issues: got %0d want %0d", hs_na - hs0, exp_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++; if (hs_a[(hs0 + i) % 512] !== exp_q[i]) begin n_fail++; $display("FAIL rst burst %0d: got %h want %h", i, hs_a[(hs0 + i) % 512], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    bit ok;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    int hs0 = hs_na, hsb0 = hs_nb, d0 = done_na, db0 = done_nb;
    exp_q.delete();
    exp_qb.delete();
    for (int i = 0; i < 36; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[11:0] = 12'hFFF - 12'($urandom_range(0, 300));
      len = 8'($urandom_range(0, 255));
      id  = 4'($urandom);
      if (i < 24) begin
        model(addr, int'(len), id, 3, 1'b0);
        push_a(len, addr, id);
      end else begin
        model(addr, int'(len), id, 0, 1'b1);
        push_b(len, addr, id);
      end
    end
    run_until(d0 + 24, db0 + 12, 3000, 1'b1, ok);
    ready = 1'b1;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL random timeout: got %0d/%0d want 24/12", done_na - d0, done_nb - db0); end
    idle(4);
    n_cmp++; if (hs_na - hs0 != exp_q.size()) begin n_fail++; $display("FAIL random issues: got %0d want %0d", hs_na - hs0, exp_q.size()); end
    n_cmp++; if (hs_nb - hsb0 != exp_qb.size()) begin n_fail++; $display("FAIL random issues_b: got %0d want %0d", hs_nb - hsb0, exp_qb.size()); end
    foreach (exp_q[i]) begin
      n_cmp++; if (hs_a[(hs0 + i) % 512] !== exp_q[i]) begin n_fail++; $display("FAIL random burst %0d: got %h want %h", i, hs_a[(hs0 + i) % 512], exp_q[i]); end
    end
    foreach (exp_qb[i]) begin
      n_cmp++; if (hs_b[(hsb0 + i) % 512] !== exp_qb[i]) begin n_fail++; $display("FAIL random burst_b %0d: got %h want %h", i, hs_b[(hsb0 + i) % 512], exp_qb[i]); end
    end
    n_cmp++; if (done_na - d0 != 24 || done_nb - db0 != 12) begin n_fail++; $display("FAIL random done: got %0d/%0d want 24/12", done_na - d0, done_nb - db0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_backpressure();
    test_max_burst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
